// File: rtl/p4_router_ing_rr_arbiter.sv
// p4_router_ing_rr_arbiter: round-robin, packet-atomic merge of N AXI-Stream ingress ports through a 2-entry skid buffer
module p4_router_ing_rr_arbiter #(
    parameter int N_PORTS       = 4,
    parameter int DATA_BYTES    = 64,
    parameter int PORT_ID_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [N_PORTS-1:0]              port_enable,
    input  logic [N_PORTS-1:0]              s_tvalid,
    output logic [N_PORTS-1:0]              s_tready,
    input  logic [N_PORTS-1:0]              s_tlast,
    input  logic [N_PORTS*DATA_BYTES*8-1:0] s_tdata,
    input  logic [N_PORTS*DATA_BYTES-1:0]   s_tkeep,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic [DATA_BYTES*8-1:0]         m_tdata,
    output logic [DATA_BYTES-1:0]           m_tkeep,
    output logic [PORT_ID_WIDTH-1:0]        m_tuser,
    output logic [N_PORTS-1:0]              grant,
    input  logic                            pkt_cnt_clear,
    output logic [N_PORTS*32-1:0]           pkt_cnt
);
    localparam int IW = $clog2(N_PORTS);
    localparam int DW = DATA_BYTES * 8;

    if (PORT_ID_WIDTH < IW) begin : g_chk
        $error("PORT_ID_WIDTH must be at least $clog2(N_PORTS)");
    end

    typedef enum logic {IDLE, XFER} state_t;

    state_t                r_state, w_next;
    logic [IW-1:0]         r_gidx, r_last, w_pick;
    logic                  w_found, w_room, w_acc, w_eop, w_pop;
    logic [N_PORTS-1:0]    w_elig, w_rot;
    logic [2*N_PORTS-1:0]  w_dbl;
    logic [DW-1:0]         r_data [2];
    logic [DATA_BYTES-1:0] r_keep [2];
    logic [IW-1:0]         r_src  [2];
    logic [1:0]            r_lastb;
    logic                  r_wp, r_rp;
    logic [1:0]            r_cnt;
    logic [N_PORTS*32-1:0] r_pkt_cnt;

    // Rotate eligibility so bit 0 is last_grant+1, then take the lowest set bit
    always_comb begin
        w_elig  = s_tvalid & port_enable;
        w_dbl   = {w_elig, w_elig} >> (int'(r_last) + 1);
        w_rot   = w_dbl[N_PORTS-1:0];
        w_found = 1'b0;
        w_pick  = r_last;
        for (int m = N_PORTS - 1; m >= 0; m--) begin
            if (w_rot[m]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(r_last) + 1 + m) % N_PORTS);
            end
        end
    end

    // Next state plus grant/ready; ready depends only on registered buffer occupancy
    always_comb begin
        w_room   = ~r_cnt[1];
        grant    = (r_state == XFER) ? (N_PORTS'(1) << r_gidx) : '0;
        s_tready = w_room ? grant : '0;
        w_acc    = (r_state == XFER) && s_tvalid[r_gidx] && w_room;
        w_eop    = w_acc && s_tlast[r_gidx];
        w_next   = (r_state == IDLE) ? (w_found ? XFER : IDLE) : (w_eop ? IDLE : XFER);
    end

    // State, latched grant index and round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gidx  <= '0;
            r_last  <= IW'(N_PORTS - 1);
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) r_gidx <= w_pick;
            if (w_eop) r_last <= r_gidx;
        end
    end

    // Head of the skid buffer drives the output
    always_comb begin
        m_tvalid = |r_cnt;
        m_tdata  = r_data[r_rp];
        m_tkeep  = r_keep[r_rp];
        m_tlast  = r_lastb[r_rp];
        m_tuser  = PORT_ID_WIDTH'(r_src[r_rp]);
        w_pop    = m_tvalid && m_tready;
    end

    // Two-entry skid buffer; entries are zeroed on reset so outputs read 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < 2; e++) begin
                r_data[e] <= '0;
                r_keep[e] <= '0;
                r_src[e]  <= '0;
            end
            r_lastb <= '0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_acc) begin
                r_data[r_wp]  <= s_tdata[r_gidx*DW +: DW];
                r_keep[r_wp]  <= s_tkeep[r_gidx*DATA_BYTES +: DATA_BYTES];
                r_src[r_wp]   <= r_gidx;
                r_lastb[r_wp] <= s_tlast[r_gidx];
                r_wp          <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(w_acc) - 2'(w_pop);
        end
    end

    // Per-port packet counters; clear wins over a coincident increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (pkt_cnt_clear)
                    r_pkt_cnt[i*32 +: 32] <= '0;
                else if (w_pop && m_tlast && r_src[r_rp] == IW'(i))
                    r_pkt_cnt[i*32 +: 32] <= r_pkt_cnt[i*32 +: 32] + 32'd1;
            end
        end
    end

    assign pkt_cnt = r_pkt_cnt;
endmodule

// File: doc/p4_router_ing_rr_arbiter.md
P4_ROUTER_ING_RR_ARBITER -- requirements
Module: p4_router_ing_rr_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, the number of ingress requesters (2..16).
REQ-002 SHALL have parameter DATA_BYTES, default 64, the tdata width in bytes for inputs and output.
REQ-003 SHALL have parameter PORT_ID_WIDTH, default 4, the m_tuser width; elaboration SHALL fail if PORT_ID_WIDTH < $clog2(N_PORTS).
REQ-004 clk  in  1  core clock; all logic is single-clock.
REQ-005 rstn  in  1  asynchronous active-low reset; assertion takes effect immediately, deassertion is synchronous to clk.
REQ-006 port_enable  in  N_PORTS  per-port arbitration eligibility, quasi-static.
REQ-007 s_tvalid / s_tready / s_tlast  in/out/in  N_PORTS each  per-port AXIS handshake.
REQ-008 s_tdata / s_tkeep  in  N_PORTS x DATA_BYTES*8 / N_PORTS x DATA_BYTES  per-port payload.
REQ-009 m_tvalid / m_tready / m_tlast  out/in/out  1 each  merged AXIS output handshake.
REQ-010 m_tdata / m_tkeep  out  DATA_BYTES*8 / DATA_BYTES  merged payload.
REQ-011 m_tuser  out  PORT_ID_WIDTH  index of the source port, zero-extended, constant for the whole packet.
REQ-012 grant  out  N_PORTS  one-hot current grant, all-zero when idle.
REQ-013 pkt_cnt_clear  in  1  synchronous clear of all pkt_cnt.
REQ-014 pkt_cnt  out  N_PORTS x 32  per-port count of packets forwarded (counted on tlast output handshake).

Function
REQ-015 SHALL implement FSM states IDLE and XFER.
REQ-016 IDLE: eligible = s_tvalid & port_enable; if any are eligible, SHALL latch the first eligible index searching upward from (last_grant+1) mod N_PORTS with wrap-around, assert grant next cycle, and enter XFER.
REQ-017 IDLE with no eligible port SHALL remain in IDLE with grant = 0 and all s_tready = 0.
REQ-018 XFER: only s_tready[g] MAY be 1; it SHALL be 1 iff the output buffer has a free entry; all other s_tready SHALL be 0.
REQ-019 XFER SHALL hold the grant until the beat with s_tlast=1 is accepted on port g, then return to IDLE and update last_grant = g; one bubble cycle between packets is mandated.
REQ-020 Deasserting port_enable[g] during XFER SHALL NOT truncate the packet; it affects only subsequent arbitration.
REQ-021 Output SHALL be a 2-entry skid buffer: latency 1 cycle from input handshake to m_tvalid; s_tready SHALL NOT combinationally depend on m_tready.
REQ-022 m_tvalid SHALL remain asserted with m_tdata, m_tkeep, m_tlast, and m_tuser stable until m_tready=1.
REQ-023 Full throughput SHALL be sustained: one beat per cycle while m_tready=1 within a packet.
REQ-024 pkt_cnt[i] SHALL increment on m_tvalid & m_tready & m_tlast when m_tuser=i, SHALL wrap at 2^32-1 to 0, and pkt_cnt_clear SHALL take priority over a simultaneous increment (result 0).
REQ-025 Beats and tkeep SHALL pass unmodified; the block SHALL NOT drop, reorder, or interleave beats from different packets.

Reset
REQ-026 On rstn=0: state=IDLE, last_grant=N_PORTS-1 (so port 0 wins first), grant=0, s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, m_tuser=0, pkt_cnt=0, skid buffer empty.
REQ-027 Reset asserted mid-packet SHALL discard buffered beats; after deassertion, the first output beat SHALL come from a fresh arbitration.

Verification
REQ-028 N_PORTS=4, all enabled, all ports continuously offer 3-beat packets, m_tready=1 -> m_tuser sequence 0,1,2,3,0,...; each packet is 3 consecutive beats followed by a 1-cycle gap.
REQ-029 Only port 2 valid, 1-beat packets back-to-back -> port 2 granted every packet, output 1 beat per 2 cycles, pkt_cnt[2] increments each packet.
REQ-030 Port 1 sending an 8-beat packet with m_tready toggling 1,0,1,0 -> all 8 beats output in order with data held stable during stalls; s_tready[other]=0 throughout.
REQ-031 port_enable=4'b1011 with all ports valid -> port 2 never granted; order is 0,1,3,0; clearing enable[1] mid-packet on port 1 completes that packet.
REQ-032 rstn pulsed low at beat 3 of a 6-beat packet -> m_tvalid=0 within the reset cycle; after release, port 0 is granted first and pkt_cnt=0.
REQ-033 pkt_cnt[0] preset near 32'hFFFFFFFF via traffic or force, then 2 packets -> pkt_cnt[0] reads 32'hFFFFFFFF then 0; pkt_cnt_clear coincident with a tlast handshake -> pkt_cnt[0] reads 0.
